// File: rtl/traffic_ctrl.sv
// traffic_ctrl: two-road phase sequencer with pedestrian walk and flashing-yellow mode
module traffic_ctrl #(
  parameter int T_GREEN  = 50,
  parameter int T_YELLOW = 20,
  parameter int T_ALLRED = 10,
  parameter int T_WALK   = 40,
  parameter int T_FLASH  = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ped_req,
  input  logic       flash_en,
  input  logic       done,
  output logic [6:0] time_slot,
  output logic       start,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_pend,
  output logic [2:0] state
);
  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_A = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_B = 3'd5,
    PED_WALK  = 3'd6,
    FLASH     = 3'd7
  } state_t;
  state_t st, nxt;
  logic ped_s1, ped_s2, ped_s3, fl_s1, fl_s2, flash_phase;
  logic adv, ped_rise, walk_entry;
  assign state      = st;
  assign adv        = start & done;
  assign ped_rise   = ped_s2 & ~ped_s3;
  assign walk_entry = adv & ~fl_s2 & (st == ALL_RED_B) & ped_pend;
  always_comb begin
    nxt = st;
    case (st)
      NS_GREEN:  nxt = NS_YELLOW;
      NS_YELLOW: nxt = ALL_RED_A;
      ALL_RED_A: nxt = EW_GREEN;
      EW_GREEN:  nxt = EW_YELLOW;
      EW_YELLOW: nxt = ALL_RED_B;
      ALL_RED_B: nxt = ped_pend ? PED_WALK : NS_GREEN;
      PED_WALK:  nxt = NS_GREEN;
      default:   nxt = FLASH;
    endcase
  end
  // Every state change drops start for one cycle so the timer restarts from zero.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st          <= ALL_RED_B;
      start       <= 1'b0;
      flash_phase <= 1'b0;
      ped_pend    <= 1'b0;
      ped_s1      <= 1'b0;
      ped_s2      <= 1'b0;
      ped_s3      <= 1'b0;
      fl_s1       <= 1'b0;
      fl_s2       <= 1'b0;
    end else begin
      ped_s1   <= ped_req;
      ped_s2   <= ped_s1;
      ped_s3   <= ped_s2;
      fl_s1    <= flash_en;
      fl_s2    <= fl_s1;
      ped_pend <= ped_rise | (ped_pend & ~walk_entry);
      if (st != FLASH && fl_s2) begin
        st          <= FLASH;
        start       <= 1'b0;
        flash_phase <= 1'b0;
      end else if (st == FLASH && !fl_s2) begin
        st    <= ALL_RED_A;
        start <= 1'b0;
      end else if (adv) begin
        st          <= nxt;
        start       <= 1'b0;
        flash_phase <= flash_phase ^ (st == FLASH);
      end else begin
        start <= 1'b1;
      end
    end
  end
  assign time_slot = (st == NS_GREEN  || st == EW_GREEN)  ? 7'(T_GREEN)  :
                     (st == NS_YELLOW || st == EW_YELLOW) ? 7'(T_YELLOW) :
                     (st == ALL_RED_A || st == ALL_RED_B) ? 7'(T_ALLRED) :
                     (st == PED_WALK)                     ? 7'(T_WALK)   : 7'(T_FLASH);
  assign ns_light = (st == NS_GREEN)  ? 3'b001 :
                    (st == NS_YELLOW) ? 3'b010 :
                    (st == FLASH)     ? {1'b0, flash_phase, 1'b0} : 3'b100;
  assign ew_light = (st == EW_GREEN)  ? 3'b001 :
                    (st == EW_YELLOW) ? 3'b010 :
                    (st == FLASH)     ? {1'b0, flash_phase, 1'b0} : 3'b100;
  assign walk = (st == PED_WALK);
endmodule

// File: tb/tb_traffic_ctrl.sv
// tb_traffic_ctrl: directed scenarios plus a randomized ped_req run against a phase-level model
module tb_traffic_ctrl;
  logic CLK = 1'b0, RST = 1'b0, ped_req = 1'b0, flash_en = 1'b0, fault = 1'b0;
  logic done, start, walk, ped_pend;
  logic [6:0] time_slot;
  logic [2:0] ns_light, ew_light, state;
  int errors = 0, checks = 0, tcnt = 0;
  int slot_t[8] = '{50, 20, 10, 50, 20, 10, 40, 5};
  logic [2:0] ns_t[8] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000};
  logic [2:0] ew_t[8] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100, 3'b100, 3'b000};
  traffic_ctrl dut (
    .CLK(CLK), .RST(RST), .ped_req(ped_req), .flash_en(flash_en), .done(done),
    .time_slot(time_slot), .start(start), .ns_light(ns_light), .ew_light(ew_light),
    .walk(walk), .ped_pend(ped_pend), .state(state)
  );
  always #5 CLK = ~CLK;
  // Phase timer stand-in: CLK_FREQ = 100, so one slot unit is 10 start-high cycles.
  always @(posedge CLK) tcnt <= start ? tcnt + 1 : 0;
  assign done = fault | (start && tcnt == int'(time_slot) * 10 - 1);
  function automatic int dur(input int s);
    return slot_t[s] * 10 + 1;
  endfunction
  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask
  task automatic apply_reset();
    @(negedge CLK);
    RST = 1'b1;
    step(2);
    RST = 1'b0;
  endtask
  task automatic wait_state(input int s);
    for (int i = 0; i < 3000 && state !== 3'(s); i++) @(negedge CLK);
    checks++;
    if (state !== 3'(s)) begin errors++; $display("FAIL wait_state timeout state=%0d want %0d", state, s); end
  endtask
  task automatic measure(output int n);
    logic [2:0] s0;
    s0 = state;
    n = 0;
    while (state === s0 && n < 5000) begin n++; @(negedge CLK); end
  endtask
  task automatic test_reset();
    @(negedge CLK);
    RST = 1'b1;
    #1;
    checks++; if (state !== 3'd5) begin errors++; $display("FAIL reset_state got %0d want 5", state); end
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", start); end
    checks++; if (ns_light !== 3'b100 || ew_light !== 3'b100) begin errors++; $display("FAIL reset_lamps got %b/%b want 100/100", ns_light, ew_light); end
    checks++; if (walk !== 1'b0 || ped_pend !== 1'b0) begin errors++; $display("FAIL reset_walk_pend got %b%b want 00", walk, ped_pend); end
    checks++; if (time_slot !== 7'd10) begin errors++; $display("FAIL reset_slot got %0d want 10", time_slot); end
    step(2);
    RST = 1'b0;
    step(1);
    checks++; if (start !== 1'b1 || state !== 3'd5) begin errors++; $display("FAIL reset_release got start=%b state=%0d want 1/5", start, state); end
  endtask
  task automatic test_free_run();
    int exp_s[7] = '{5, 0, 1, 2, 3, 4, 5};
    int exp_n[7] = '{101, 501, 201, 101, 501, 201, 101};
    int n;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      checks++; if (state !== 3'(exp_s[i])) begin errors++; $display("FAIL free_state[%0d] got %0d want %0d", i, state, exp_s[i]); end
      measure(n);
      checks++; if (n != exp_n[i]) begin errors++; $display("FAIL free_len[%0d] got %0d want %0d", i, n, exp_n[i]); end
    end
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL free_no_walk got %0d want 0", state); end
  endtask
  task automatic test_done_fault();
    apply_reset();
    fault = 1'b1;
    step(1);
    checks++; if (state !== 3'd5 || start !== 1'b1) begin errors++; $display("FAIL fault_gap got %0d/%b want 5/1", state, start); end
    step(1);
    checks++; if (state !== 3'd0 || start !== 1'b0) begin errors++; $display("FAIL fault_adv got %0d/%b want 0/0", state, start); end
    step(1);
    fault = 1'b0;
    checks++; if (state !== 3'd0 || start !== 1'b1) begin errors++; $display("FAIL fault_once got %0d/%b want 0/1", state, start); end
    step(1);
    checks++; if (state !== 3'd0 || start !== 1'b1) begin errors++; $display("FAIL fault_after got %0d/%b want 0/1", state, start); end
  endtask
  task automatic test_ped();
    int n;
    wait_state(3);
    step(100);
    ped_req = 1'b1;
    step(2);
    checks++; if (ped_pend !== 1'b0) begin errors++; $display("FAIL ped_early got %b want 0", ped_pend); end
    step(1);
    checks++; if (ped_pend !== 1'b1) begin errors++; $display("FAIL ped_latch got %b want 1", ped_pend); end
    step(2);
    ped_req = 1'b0;
    wait_state(5);
    measure(n);
    checks++; if (n != 101) begin errors++; $display("FAIL ped_allred got %0d want 101", n); end
    checks++; if (state !== 3'd6 || walk !== 1'b1) begin errors++; $display("FAIL ped_walk got %0d/%b want 6/1", state, walk); end
    checks++; if (ns_light !== 3'b100 || ew_light !== 3'b100) begin errors++; $display("FAIL ped_lamps got %b/%b want 100/100", ns_light, ew_light); end
    checks++; if (ped_pend !== 1'b0) begin errors++; $display("FAIL ped_clear got %b want 0", ped_pend); end
    measure(n);
    checks++; if (n != 401) begin errors++; $display("FAIL ped_len got %0d want 401", n); end
    checks++; if (state !== 3'd0 || walk !== 1'b0) begin errors++; $display("FAIL ped_exit got %0d/%b want 0/0", state, walk); end
  endtask
  task automatic test_coincident();
    int n;
    wait_state(3);
    step(10);
    ped_req = 1'b1;
    step(5);
    ped_req = 1'b0;
    wait_state(5);
    step(98);
    ped_req = 1'b1;
    step(3);
    checks++; if (state !== 3'd6 || ped_pend !== 1'b1) begin errors++; $display("FAIL coin_entry got %0d/%b want 6/1", state, ped_pend); end
    step(10);
    ped_req = 1'b0;
    wait_state(5);
    measure(n);
    checks++; if (state !== 3'd6 || ped_pend !== 1'b0) begin errors++; $display("FAIL coin_second got %0d/%b want 6/0", state, ped_pend); end
  endtask
  task automatic test_flash();
    int n;
    wait_state(0);
    step(100);
    flash_en = 1'b1;
    step(2);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL flash_early got %0d want 0", state); end
    step(1);
    checks++; if (state !== 3'd7 || start !== 1'b0) begin errors++; $display("FAIL flash_entry got %0d/%b want 7/0", state, start); end
    checks++; if (ns_light !== 3'b000 || ew_light !== 3'b000) begin errors++; $display("FAIL flash_lamps0 got %b/%b want 000/000", ns_light, ew_light); end
    step(1);
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL flash_gap got %b want 1", start); end
    n = 1;
    while (ns_light === 3'b000 && n < 1000) begin n++; step(1); end
    checks++; if (n != 51) begin errors++; $display("FAIL flash_off_len got %0d want 51", n); end
    checks++; if (ns_light !== 3'b010 || ew_light !== 3'b010) begin errors++; $display("FAIL flash_lamps1 got %b/%b want 010/010", ns_light, ew_light); end
    n = 0;
    while (ns_light === 3'b010 && n < 1000) begin n++; step(1); end
    checks++; if (n != 51) begin errors++; $display("FAIL flash_on_len got %0d want 51", n); end
    flash_en = 1'b0;
    step(2);
    checks++; if (state !== 3'd7) begin errors++; $display("FAIL flash_hold got %0d want 7", state); end
    step(1);
    checks++; if (state !== 3'd2 || start !== 1'b0) begin errors++; $display("FAIL flash_exit got %0d/%b want 2/0", state, start); end
    measure(n);
    checks++; if (n != 101 || state !== 3'd3) begin errors++; $display("FAIL flash_resume got len=%0d state=%0d want 101/3", n, state); end
  endtask
  task automatic test_reset_mid();
    int n;
    wait_state(3);
    step(10);
    ped_req = 1'b1;
    step(5);
    ped_req = 1'b0;
    wait_state(4);
    step(50);
    RST = 1'b1;
    #1;
    checks++; if (state !== 3'd5 || start !== 1'b0 || time_slot !== 7'd10) begin errors++; $display("FAIL mid_state got %0d/%b/%0d want 5/0/10", state, start, time_slot); end
    checks++; if (ns_light !== 3'b100 || ew_light !== 3'b100 || walk !== 1'b0) begin errors++; $display("FAIL mid_lamps got %b/%b/%b want 100/100/0", ns_light, ew_light, walk); end
    checks++; if (ped_pend !== 1'b0) begin errors++; $display("FAIL mid_pend got %b want 0", ped_pend); end
    step(2);
    RST = 1'b0;
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL mid_release got %b want 0", start); end
    step(1);
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL mid_start got %b want 1", start); end
    measure(n);
    checks++; if (n != 100 || state !== 3'd0) begin errors++; $display("FAIL mid_discard got len=%0d state=%0d want 100/0", n, state); end
  endtask
  task automatic test_random();
    bit pins[$];
    int st = 5, left = 101, nx;
    bit pend = 1'b0, p = 1'b0, rise, ent;
    logic [19:0] got, want;
    apply_reset();
    repeat (4) pins.push_back(1'b0);
    for (int k = 1; k <= 6000; k++) begin
      if ($urandom_range(0, 249) == 0) p = ~p;
      ped_req = p;
      pins.push_back(p);
      step(1);
      rise = pins[k + 1] & ~pins[k];
      left--;
      ent = 1'b0;
      if (left == 0) begin
        nx = (st == 5) ? (pend ? 6 : 0) : (st == 6) ? 0 : st + 1;
        ent = (nx == 6);
        st = nx;
        left = dur(st);
      end
      pend = rise | (pend & ~ent);
      want = {3'(st), pend, st == 6, ns_t[st], ew_t[st], 7'(slot_t[st]), left != dur(st)};
      got = {state, ped_pend, walk, ns_light, ew_light, time_slot, start};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random cycle %0d got %h want %h", k, got, want);
        break;
      end
    end
    ped_req = 1'b0;
  endtask
  initial begin
    test_reset();
    test_free_run();
    test_done_fault();
    test_ped();
    test_coincident();
    test_flash();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
